// File: rtl/pgen_ctrl.sv
// Register-mapped controller for pulse_gen and lfsr_32: shadow registers,
// apply sequencing into the datapath, and a timed pulse acquisition window.
module pgen_ctrl #(
   parameter int P_CNT_W   = 32,
   parameter int P_WIN_DEF = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  cfg_addr,
   input  logic [31:0] cfg_wdata,
   input  logic        cfg_wr,
   input  logic        cfg_rd,
   output logic [31:0] cfg_rdata,
   output logic        cfg_rvalid,
   output logic [31:0] x_low,
   output logic        x_low_wr,
   output logic [31:0] x_high,
   output logic        x_high_wr,
   output logic [31:0] seed,
   output logic        seed_wr,
   input  logic        pulse_in,
   output logic        pulse_gated,
   output logic        busy,
   output logic        done_irq
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY_SEED,
      S_APPLY_LOW,
      S_APPLY_HIGH,
      S_RUN,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [31:0]        sh_x_low, sh_x_high, sh_seed, window;
   logic [31:0]        remaining;
   logic [P_CNT_W-1:0] pulse_cnt, elapsed;
   logic               done_f, aborted_f, err_zero_win;
   logic [31:0]        rd_mux;

   logic ctrl_wr, start, abort_c, apply;
   logic idle_like, win_zero, last;

   assign ctrl_wr   = cfg_wr && (cfg_addr == 3'd0);
   assign start     = ctrl_wr && cfg_wdata[0];
   assign abort_c   = ctrl_wr && cfg_wdata[1];
   assign apply     = ctrl_wr && cfg_wdata[2];
   assign idle_like = (state == S_IDLE) || (state == S_DONE);
   assign win_zero  = (window == 32'd0);
   assign last      = (remaining == 32'd1);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (apply)                  state_nxt = S_APPLY_SEED;
            else if (start && !win_zero) state_nxt = S_RUN;
         end
         S_APPLY_SEED: state_nxt = S_APPLY_LOW;
         S_APPLY_LOW:  state_nxt = S_APPLY_HIGH;
         S_APPLY_HIGH: state_nxt = S_IDLE;
         S_RUN: begin
            if (abort_c)   state_nxt = S_IDLE;
            else if (last) state_nxt = S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      seed_wr   = (state == S_APPLY_SEED);
      x_low_wr  = (state == S_APPLY_LOW);
      x_high_wr = (state == S_APPLY_HIGH);
      busy      = seed_wr || x_low_wr || x_high_wr || (state == S_RUN);
   end

   // Shadow registers and the buses they feed
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_x_low  <= 32'd0;
         sh_x_high <= 32'd0;
         sh_seed   <= 32'hFFFF_FFFF;
         window    <= 32'(P_WIN_DEF);
         x_low     <= 32'd0;
         x_high    <= 32'd0;
         seed      <= 32'hFFFF_FFFF;
      end else begin
         if (cfg_wr) begin
            case (cfg_addr)
               3'd1:    sh_x_low  <= cfg_wdata;
               3'd2:    sh_x_high <= cfg_wdata;
               3'd3:    sh_seed   <= cfg_wdata;
               3'd4:    window    <= cfg_wdata;
               default: ;
            endcase
         end
         if (state_nxt == S_APPLY_SEED) seed   <= sh_seed;
         if (state_nxt == S_APPLY_LOW)  x_low  <= sh_x_low;
         if (state_nxt == S_APPLY_HIGH) x_high <= sh_x_high;
      end
   end

   // Acquisition window counters and status flags
   always_ff @(posedge clk) begin
      if (rst) begin
         remaining    <= 32'd0;
         pulse_cnt    <= '0;
         elapsed      <= '0;
         done_f       <= 1'b0;
         aborted_f    <= 1'b0;
         err_zero_win <= 1'b0;
         done_irq     <= 1'b0;
         pulse_gated  <= 1'b0;
      end else begin
         done_irq    <= 1'b0;
         pulse_gated <= pulse_in && (state == S_RUN);
         if (idle_like && start && !apply) begin
            if (win_zero) begin
               err_zero_win <= 1'b1;
            end else begin
               remaining <= window;
               pulse_cnt <= '0;
               elapsed   <= '0;
               done_f    <= 1'b0;
               aborted_f <= 1'b0;
            end
         end
         if (state == S_RUN) begin
            if (abort_c) begin
               aborted_f <= 1'b1;
            end else begin
               remaining <= remaining - 32'd1;
               elapsed   <= elapsed + 1'b1;
               if (pulse_in && (pulse_cnt != '1))
                  pulse_cnt <= pulse_cnt + 1'b1;
               if (last) begin
                  done_f   <= 1'b1;
                  done_irq <= 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      rd_mux = 32'd0;
      case (cfg_addr)
         3'd1:    rd_mux = sh_x_low;
         3'd2:    rd_mux = sh_x_high;
         3'd3:    rd_mux = sh_seed;
         3'd4:    rd_mux = window;
         3'd5:    rd_mux = {28'd0, err_zero_win, aborted_f, done_f, busy};
         3'd6:    rd_mux = 32'(pulse_cnt);
         3'd7:    rd_mux = 32'(elapsed);
         default: rd_mux = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_rdata  <= 32'd0;
         cfg_rvalid <= 1'b0;
      end else begin
         cfg_rvalid <= cfg_rd;
         cfg_rdata  <= cfg_rd ? rd_mux : 32'd0;
      end
   end

endmodule

// File: tb/tb_pgen_ctrl.sv
// Directed bench for pgen_ctrl: register reads via an expected-value queue,
// apply sequencing, windows, abort, zero window, saturation and reset.
module tb_pgen_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  cfg_addr = 3'd0;
   logic [31:0] cfg_wdata = 32'd0;
   logic        cfg_wr = 1'b0;
   logic        cfg_rd = 1'b0;
   logic        pulse_in = 1'b0;

   logic [31:0] cfg_rdata, x_low, x_high, seed;
   logic        cfg_rvalid, x_low_wr, x_high_wr, seed_wr;
   logic        pulse_gated, busy, done_irq;

   logic [31:0] cfg_rdata4, x_low4, x_high4, seed4;
   logic        cfg_rvalid4, x_low_wr4, x_high_wr4, seed_wr4;
   logic        pulse_gated4, busy4, done_irq4;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp4_q[$];
   int irq_cnt, gate_cnt, busy_cnt;

   always #5 clk = ~clk;

   pgen_ctrl dut (
      .clk(clk), .rst(rst),
      .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cfg_wr(cfg_wr), .cfg_rd(cfg_rd),
      .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid),
      .x_low(x_low), .x_low_wr(x_low_wr),
      .x_high(x_high), .x_high_wr(x_high_wr),
      .seed(seed), .seed_wr(seed_wr),
      .pulse_in(pulse_in), .pulse_gated(pulse_gated),
      .busy(busy), .done_irq(done_irq)
   );

   pgen_ctrl #(.P_CNT_W(4)) dut4 (
      .clk(clk), .rst(rst),
      .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cfg_wr(cfg_wr), .cfg_rd(cfg_rd),
      .cfg_rdata(cfg_rdata4), .cfg_rvalid(cfg_rvalid4),
      .x_low(x_low4), .x_low_wr(x_low_wr4),
      .x_high(x_high4), .x_high_wr(x_high_wr4),
      .seed(seed4), .seed_wr(seed_wr4),
      .pulse_in(pulse_in), .pulse_gated(pulse_gated4),
      .busy(busy4), .done_irq(done_irq4)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (done_irq)    irq_cnt++;
      if (pulse_gated) gate_cnt++;
      if (busy)        busy_cnt++;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      cfg_addr  = a;
      cfg_wdata = d;
      cfg_wr    = 1'b1;
      step();
      cfg_wr = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] exp,
                     input string tag, input bit c4 = 1'b0,
                     input logic [31:0] e4 = 32'd0);
      cfg_addr = a;
      cfg_rd   = 1'b1;
      exp_q.push_back(exp);
      if (c4) exp4_q.push_back(e4);
      step();
      cfg_rd = 1'b0;
      chk({tag, "_rvalid"}, {31'd0, cfg_rvalid}, 32'd1);
      chk(tag, cfg_rdata, exp_q.pop_front());
      if (c4) chk({tag, "_w4"}, cfg_rdata4, exp4_q.pop_front());
   endtask

   initial begin
      logic [7:0] pat;
      pat = 8'b0101_0010;
      irq_cnt = 0; gate_cnt = 0; busy_cnt = 0;

      // reset values
      repeat (2) step();
      chk("rst_seed", seed, 32'hFFFF_FFFF);
      chk("rst_xlow", x_low, 32'd0);
      chk("rst_outs", {26'd0, busy, done_irq, pulse_gated, cfg_rvalid,
                       seed_wr, x_low_wr}, 32'd0);
      rst = 1'b0;
      rd(3'd3, 32'hFFFF_FFFF, "rd_seed");
      rd(3'd4, 32'd1000, "rd_window");
      rd(3'd0, 32'd0, "rd_ctrl");

      // apply sequence
      wr(3'd1, 32'h10);
      wr(3'd2, 32'h80);
      wr(3'd3, 32'h1234);
      busy_cnt = 0;
      wr(3'd0, 32'h4);
      chk("ap_seed", {seed_wr, x_low_wr, x_high_wr, busy}, 4'b1001);
      chk("ap_seed_bus", seed, 32'h1234);
      step();
      chk("ap_low", {seed_wr, x_low_wr, x_high_wr, busy}, 4'b0101);
      chk("ap_low_bus", x_low, 32'h10);
      step();
      chk("ap_high", {seed_wr, x_low_wr, x_high_wr, busy}, 4'b0011);
      chk("ap_high_bus", x_high, 32'h80);
      step();
      chk("ap_end", {seed_wr, x_low_wr, x_high_wr, busy}, 4'b0000);
      chk("ap_busy_cnt", busy_cnt, 32'd3);

      // simultaneous read and write returns the old value
      cfg_addr = 3'd1; cfg_wdata = 32'h55; cfg_rd = 1'b1; cfg_wr = 1'b1;
      exp_q.push_back(32'h10);
      step();
      cfg_rd = 1'b0; cfg_wr = 1'b0;
      chk("rw_old", cfg_rdata, exp_q.pop_front());
      rd(3'd1, 32'h55, "rw_new");

      // 8-cycle window with 3 pulses
      wr(3'd4, 32'd8);
      irq_cnt = 0; gate_cnt = 0;
      wr(3'd0, 32'h1);
      chk("run_busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         pulse_in = pat[i];
         step();
         chk("run_gate", {31'd0, pulse_gated}, {31'd0, pat[i]});
      end
      pulse_in = 1'b1;
      repeat (2) step();
      pulse_in = 1'b0;
      repeat (2) step();
      chk("w8_irq_cnt", irq_cnt, 32'd1);
      chk("w8_gate_cnt", gate_cnt, 32'd3);
      rd(3'd6, 32'd3, "w8_pcnt");
      rd(3'd7, 32'd8, "w8_elapsed");
      rd(3'd5, 32'h2, "w8_status");

      // abort at RUN cycle 10
      wr(3'd4, 32'd100);
      irq_cnt = 0;
      wr(3'd0, 32'h1);
      pulse_in = 1'b1;
      repeat (10) step();
      wr(3'd0, 32'h2);
      chk("ab_busy", {31'd0, busy}, 32'd0);
      repeat (3) step();
      pulse_in = 1'b0;
      chk("ab_irq_cnt", irq_cnt, 32'd0);
      rd(3'd6, 32'd10, "ab_pcnt");
      rd(3'd7, 32'd10, "ab_elapsed");
      rd(3'd5, 32'h4, "ab_status");

      // zero window
      wr(3'd4, 32'd0);
      busy_cnt = 0;
      wr(3'd0, 32'h1);
      repeat (3) step();
      chk("zw_busy_cnt", busy_cnt, 32'd0);
      rd(3'd5, 32'hC, "zw_status");

      // apply and start together: apply wins
      wr(3'd4, 32'd5);
      wr(3'd0, 32'h5);
      chk("as_seed_wr", {31'd0, seed_wr}, 32'd1);
      repeat (3) step();
      chk("as_idle", {31'd0, busy}, 32'd0);
      rd(3'd6, 32'd10, "as_pcnt");

      // 20-cycle window, saturation in the 4-bit instance
      wr(3'd4, 32'd20);
      irq_cnt = 0;
      wr(3'd0, 32'h1);
      pulse_in = 1'b1;
      repeat (20) step();
      pulse_in = 1'b0;
      step();
      chk("sat_irq_cnt", irq_cnt, 32'd1);
      rd(3'd6, 32'd20, "sat_pcnt", 1'b1, 32'd15);
      rd(3'd5, 32'hA, "sat_status");

      // reset mid-RUN
      wr(3'd4, 32'd50);
      wr(3'd0, 32'h1);
      pulse_in = 1'b1;
      repeat (5) step();
      chk("mr_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      step();
      chk("mr_outs", {26'd0, busy, done_irq, pulse_gated, cfg_rvalid,
                      seed_wr, x_high_wr}, 32'd0);
      chk("mr_bus", {seed, x_low}, {32'hFFFF_FFFF, 32'd0});
      chk("mr_rdata", cfg_rdata, 32'd0);
      rst = 1'b0;
      pulse_in = 1'b0;
      rd(3'd4, 32'd1000, "mr_window");
      rd(3'd6, 32'd0, "mr_pcnt");
      rd(3'd5, 32'd0, "mr_status");

      // reset mid-APPLY cuts the strobe sequence
      wr(3'd0, 32'h4);
      chk("ma_seed_wr", {31'd0, seed_wr}, 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("ma_cut", {seed_wr, x_low_wr, x_high_wr, busy}, 4'b0000);
      step();
      chk("ma_after", {seed_wr, x_low_wr, x_high_wr, busy}, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
